s3g_tx_arbiter: RTL and testbench

Shares the single host UART transmitter between two S3G packet producers: port 0 carries command responses from the S3G executor, port 1 carries asynchronous reports from the buffer executor. The arbiter grants one requester for a whole packet. It then frames that packet on the byte stream as 0xD5, length, payload and CRC-8, pacing every byte on the transceiver's `tx_wr`/`tx_done` handshake. Port 0 has fixed priority, with a starvation limit that protects port 1.

---
 rtl/s3g_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_s3g_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3g_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// s3g_tx_arbiter
//
// Shares the host UART transmitter between two S3G packet producers.
// Port 0 (command responses from the S3G executor) has fixed priority.
// Port 1 (asynchronous reports from the buffer executor) is protected by a
// starvation counter: once port 0 has been granted STARVE_LIMIT times in a
// row while port 1 was waiting, a waiting port-1 request wins the next
// arbitration.
//
// A grant covers a whole packet. The packet is framed on the byte stream as:
//   0xD5, length, payload[0..length-1], CRC-8/MAXIM(payload)
// Every byte is paced by the transceiver's tx_wr / tx_done handshake.
//
// Parameters
//   STARVE_LIMIT  consecutive contended port-0 grants before port 1 is
//                 forced through (1..15)
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   req0_i/req1_i  level request, held by the producer until its done pulse
//   len0_i/len1_i  payload length, sampled at grant
//   data0_i/data1_i current payload byte, valid while the matching rd is high
//   rd0_o/rd1_o    one-cycle pulse: byte taken, producer advances
//   gnt0_o/gnt1_o  level grant, from grant until the CRC byte completes
//   done0_o/done1_o one-cycle pulse after the final tx_done of the packet
//   tx_data_o      byte to the transceiver, stable until the next write
//   tx_wr_o        one-cycle write strobe to the transceiver
//   tx_done_i      one-cycle pulse from the transceiver, byte sent
//   busy_o         high whenever the arbiter is not idle
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module s3g_tx_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [7:0]        len0_i,
    input  logic [7:0]        len1_i,
    input  logic [7:0]        data0_i,
    input  logic [7:0]        data1_i,
    output logic              rd0_o,
    output logic              rd1_o,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_wr_o,
    input  logic              tx_done_i,
    output logic              busy_o
);

    localparam int unsigned    DATA_W      = 8;
    localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hD5;
    localparam logic [3:0]     STARVE_LIM4 = 4'(STARVE_LIMIT);

    // Byte states (SYNC, LEN, PAY, CRC) are the cycles in which that byte is
    // handed to the transceiver; WAIT is entered after every tx_wr and is the
    // only state that listens to tx_done.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CRC,
        S_WAIT,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    state_e              last_q,  last_d;   // byte state that led into WAIT
    logic                port_q,  port_d;   // 0 = port 0 owns the packet
    logic [DATA_W-1:0]   rem_q,   rem_d;
    logic [DATA_W-1:0]   crc_q,   crc_d;
    logic [3:0]          starve_q, starve_d;
    logic                ph_q,    ph_d;     // PAY sub-phase: 0 = rd, 1 = write
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_wr_q, tx_wr_d;
    logic                rd0_q,   rd0_d;
    logic                rd1_q,   rd1_d;
    logic                gnt0_q,  gnt0_d;
    logic                gnt1_q,  gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                busy_q,  busy_d;

    logic                pick0, pick1;
    logic [DATA_W-1:0]   pay_byte;

    // CRC-8/MAXIM, reflected polynomial 0x8C, one byte folded per call.
    function automatic logic [DATA_W-1:0] crc8_update(
        input logic [DATA_W-1:0] crc,
        input logic [DATA_W-1:0] din
    );
        logic [DATA_W-1:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = {1'b0, c[DATA_W-1:1]} ^ 8'h8C;
            end else begin
                c = {1'b0, c[DATA_W-1:1]};
            end
        end
        return c;
    endfunction

    // Arbitration: port 1 wins when it is alone, or when port 0 has starved
    // it for STARVE_LIMIT packets; otherwise port 0 has priority.
    always_comb begin
        pick1 = req1_i && (!req0_i || (starve_q >= STARVE_LIM4));
        pick0 = req0_i && !pick1;
    end

    assign pay_byte = port_q ? data1_i : data0_i;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        port_d    = port_q;
        rem_d     = rem_q;
        crc_d     = crc_q;
        starve_d  = starve_q;
        ph_d      = ph_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        rd0_d     = 1'b0;
        rd1_d     = 1'b0;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick0 || pick1) begin
                    state_d   = S_SYNC;
                    port_d    = pick1;
                    rem_d     = pick1 ? len1_i : len0_i;
                    crc_d     = '0;
                    gnt0_d    = pick0;
                    gnt1_d    = pick1;
                    tx_wr_d   = 1'b1;
                    tx_data_d = SYNC_BYTE;
                    if (pick1) begin
                        starve_d = '0;
                    end else if (req1_i && (starve_q != 4'hF)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end

            S_SYNC: begin
                state_d = S_WAIT;
                last_d  = S_SYNC;
            end

            S_LEN: begin
                state_d = S_WAIT;
                last_d  = S_LEN;
            end

            S_PAY: begin
                if (!ph_q) begin
                    // rd is high this cycle; the producer presents the byte now.
                    tx_data_d = pay_byte;
                    crc_d     = crc8_update(crc_q, pay_byte);
                    rem_d     = rem_q - 8'd1;
                    tx_wr_d   = 1'b1;
                    ph_d      = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    last_d  = S_PAY;
                end
            end

            S_CRC: begin
                state_d = S_WAIT;
                last_d  = S_CRC;
            end

            S_WAIT: begin
                if (tx_done_i) begin
                    case (last_q)
                        S_SYNC: begin
                            // rem still holds the untouched latched length.
                            state_d   = S_LEN;
                            tx_wr_d   = 1'b1;
                            tx_data_d = rem_q;
                        end
                        S_LEN, S_PAY: begin
                            if (rem_q != '0) begin
                                state_d = S_PAY;
                                ph_d    = 1'b0;
                                rd0_d   = !port_q;
                                rd1_d   = port_q;
                            end else begin
                                state_d   = S_CRC;
                                tx_wr_d   = 1'b1;
                                tx_data_d = crc_q;
                            end
                        end
                        default: begin
                            state_d = S_FIN;
                            done0_d = !port_q;
                            done1_d = port_q;
                        end
                    endcase
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            last_q    <= S_IDLE;
            port_q    <= 1'b0;
            rem_q     <= '0;
            crc_q     <= '0;
            starve_q  <= '0;
            ph_q      <= 1'b0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            rd0_q     <= 1'b0;
            rd1_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            port_q    <= port_d;
            rem_q     <= rem_d;
            crc_q     <= crc_d;
            starve_q  <= starve_d;
            ph_q      <= ph_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
        end
    end

    assign rd0_o     = rd0_q;
    assign rd1_o     = rd1_q;
    assign gnt0_o    = gnt0_q;
    assign gnt1_o    = gnt1_q;
    assign done0_o   = done0_q;
    assign done1_o   = done1_q;
    assign tx_data_o = tx_data_q;
    assign tx_wr_o   = tx_wr_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
`timescale 1ns/1ps
module tb_s3g_tx_arbiter;

    localparam int HALF     = 50;   // 10 MHz clock
    localparam int BAUD_CYC = 100;  // 10 bit times at 1 Mbaud
    localparam int TO       = 4000; // cycle budget for any single wait

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] len0 = 8'h00, len1 = 8'h00;
    logic [7:0] data0, data1;
    logic       rd0, rd1, gnt0, gnt1, done0, done1;
    logic [7:0] tx_data;
    logic       tx_wr, tx_done, busy;
    logic       stray_en = 1'b0;

    always #HALF clk = ~clk;

    s3g_tx_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req0_i    (req0),
        .req1_i    (req1),
        .len0_i    (len0),
        .len1_i    (len1),
        .data0_i   (data0),
        .data1_i   (data1),
        .rd0_o     (rd0),
        .rd1_o     (rd1),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1),
        .done0_o   (done0),
        .done1_o   (done1),
        .tx_data_o (tx_data),
        .tx_wr_o   (tx_wr),
        .tx_done_i (tx_done),
        .busy_o    (busy)
    );

    // Producers: present pay[idx] combinationally, advance on rd.
    logic [7:0] pay0 [16];
    logic [7:0] pay1 [16];
    logic [3:0] idx0 = 4'd0, idx1 = 4'd0;
    assign data0 = pay0[idx0];
    assign data1 = pay1[idx1];

    always @(posedge clk) begin
        if (!gnt0) idx0 <= 4'd0;
        else if (rd0) idx0 <= idx0 + 4'd1;
        if (!gnt1) idx1 <= 4'd0;
        else if (rd1) idx1 <= idx1 + 4'd1;
    end

    // Transceiver: tx_done one byte time after each tx_wr.
    int   xc_cnt = 0;
    logic xc_done = 1'b0;
    always @(posedge clk) begin
        xc_done <= 1'b0;
        if (!rst_n) begin
            xc_cnt <= 0;
        end else if (tx_wr) begin
            xc_cnt <= BAUD_CYC;
        end else if (xc_cnt != 0) begin
            xc_cnt <= xc_cnt - 1;
            if (xc_cnt == 1) xc_done <= 1'b1;
        end
    end

    // Stray completions land only in cycles where the arbiter is in a byte
    // state or FIN, never in WAIT.
    assign tx_done = xc_done | (stray_en & (tx_wr | rd0 | rd1 | done0 | done1));

    // Scoreboard state
    logic [7:0] exp_q [$];
    int         exp_g [$];
    int n_cmp = 0, n_err = 0;
    int wr_cnt = 0, rd0_cnt = 0, rd1_cnt = 0, d0_cnt = 0, d1_cnt = 0;
    int s_wr, s_rd0, s_rd1, s_d0, s_d1;
    logic excl_bad = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {busy, gnt0, gnt1, rd0, rd1, done0, done1, tx_wr, tx_data};
    endfunction

    // Bit-serial reference: LSB first, feedback into reflected 0x8C.
    function automatic logic [7:0] ref_crc(input logic [7:0] p [8], input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ p[k][b];
                c  = {1'b0, c[7:1]};
                if (fb) c = c ^ 8'h8C;
            end
        end
        return c;
    endfunction

    task automatic push_packet(input int len, input logic [7:0] p [8], input logic [7:0] crc);
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'(len));
        for (int k = 0; k < len; k++) exp_q.push_back(p[k]);
        exp_q.push_back(crc);
    endtask

    task automatic snap();
        s_wr = wr_cnt; s_rd0 = rd0_cnt; s_rd1 = rd1_cnt; s_d0 = d0_cnt; s_d1 = d1_cnt;
    endtask

    // Monitor: byte scoreboard, grant order and handshake timing.
    initial begin : monitor
        logic prev_rd, prev_xc, prev_g0, prev_g1;
        prev_rd = 1'b0; prev_xc = 1'b0; prev_g0 = 1'b0; prev_g1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rd = 1'b0; prev_xc = 1'b0; prev_g0 = 1'b0; prev_g1 = 1'b0;
            end else begin
                if (gnt0 && gnt1) excl_bad = 1'b1;
                if (prev_rd) chk("rd_to_wr", int'(tx_wr), 1);
                if (prev_xc) chk("txdone_response", $countones({tx_wr, rd0, rd1, done0, done1}), 1);
                if (tx_wr) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL tx_byte: got 0x%02h, want no byte", tx_data);
                    end else begin
                        chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
                    end
                end
                if ((gnt0 && !prev_g0) || (gnt1 && !prev_g1)) begin
                    if (exp_g.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL grant_port: got port %0d, want no grant", int'(gnt1));
                    end else begin
                        chk("grant_port", int'(gnt1), exp_g.pop_front());
                    end
                end
                if (rd0) rd0_cnt++;
                if (rd1) rd1_cnt++;
                if (done0) d0_cnt++;
                if (done1) d1_cnt++;
                prev_rd = rd0 | rd1;
                prev_xc = xc_done;
                prev_g0 = gnt0;
                prev_g1 = gnt1;
            end
        end
    end

    task automatic start_packet(input int port, input int len, input logic [7:0] p [8],
                                input logic [7:0] crc);
        push_packet(len, p, crc);
        exp_g.push_back(port);
        for (int k = 0; k < 8; k++) begin
            if (port == 1) pay1[k] = p[k];
            else           pay0[k] = p[k];
        end
        if (port == 1) len1 = 8'(len);
        else           len0 = 8'(len);
        snap();
        if (port == 1) req1 = 1'b1;
        else           req0 = 1'b1;
        @(negedge clk);
        chk("grant_latency", int'({gnt0, gnt1, tx_wr, busy, tx_data}),
            int'({(port == 0), (port == 1), 1'b1, 1'b1, 8'hD5}));
    endtask

    task automatic finish_packet(input int port, input int len);
        int   t;
        logic d;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            d = (port == 1) ? done1 : done0;
        end while (!d && t < TO);
        if (!d) begin
            chk("done_timeout", 0, 1);
            req0 = 1'b0; req1 = 1'b0;
        end else begin
            chk("gnt_at_done", int'((port == 1) ? gnt1 : gnt0), 1);
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            chk("gnt_fall", int'({gnt0, gnt1, busy}), 0);
            repeat (2) @(negedge clk);
            chk("wr_count", wr_cnt - s_wr, len + 3);
            chk("rd_count", (port == 1) ? rd1_cnt - s_rd1 : rd0_cnt - s_rd0, len);
            chk("rd_other", (port == 1) ? rd0_cnt - s_rd0 : rd1_cnt - s_rd1, 0);
            chk("done_count", (port == 1) ? d1_cnt - s_d1 : d0_cnt - s_d0, 1);
            chk("done_other", (port == 1) ? d0_cnt - s_d0 : d1_cnt - s_d1, 0);
            chk("bytes_left", exp_q.size(), 0);
        end
    endtask

    typedef struct {
        int         port;
        int         len;
        logic [7:0] pay [8];
        logic [7:0] crc;
    } vec_t;

    vec_t vt [6];

    initial begin : main
        logic [7:0] pa [8];
        logic [7:0] pb [8];
        int order [6];
        int t, seen;

        for (int k = 0; k < 16; k++) begin pay0[k] = 8'h00; pay1[k] = 8'h00; end

        vt[0].port = 0; vt[0].len = 1;
        vt[0].pay = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[0].crc = 8'hD2;
        vt[1].port = 1; vt[1].len = 4;
        vt[1].pay = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[1].crc = ref_crc(vt[1].pay, 4);
        vt[2].port = 1; vt[2].len = 0;
        vt[2].pay = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2].crc = 8'h00;
        vt[3].port = 0; vt[3].len = 1;
        vt[3].pay = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[3].crc = 8'hB3;
        vt[4].port = 0; vt[4].len = 3;
        vt[4].pay = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[4].crc = ref_crc(vt[4].pay, 3);
        vt[5].port = 1; vt[5].len = 8;
        vt[5].pay = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        vt[5].crc = ref_crc(vt[5].pay, 8);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(outs()), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'(outs()), 0);

        // Table of single packets
        for (int i = 0; i < 6; i++) begin
            start_packet(vt[i].port, vt[i].len, vt[i].pay, vt[i].crc);
            finish_packet(vt[i].port, vt[i].len);
        end

        // Contention: port 0 wins four, port 1 the fifth, then port 0 again
        pa = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pb = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        order = '{0, 0, 0, 0, 1, 0};
        for (int k = 0; k < 8; k++) begin pay0[k] = pa[k]; pay1[k] = pb[k]; end
        len0 = 8'd2; len1 = 8'd1;
        for (int k = 0; k < 6; k++) begin
            if (order[k] == 1) push_packet(1, pb, 8'hB3);
            else               push_packet(2, pa, ref_crc(pa, 2));
            exp_g.push_back(order[k]);
        end
        snap();
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!(done0 || done1) && t < TO);
            if (!(done0 || done1)) begin
                chk("arb_timeout", 0, 1);
                break;
            end
            chk("arb_winner", int'(done1), order[k]);
            if (k == 5) begin
                req0 = 1'b0; req1 = 1'b0;
            end else if (done1) begin
                req1 = 1'b0; @(negedge clk); req1 = 1'b1;
            end else begin
                req0 = 1'b0; @(negedge clk); req0 = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("arb_wr_count", wr_cnt - s_wr, 29);
        chk("arb_rd0_count", rd0_cnt - s_rd0, 10);
        chk("arb_rd1_count", rd1_cnt - s_rd1, 1);
        chk("arb_bytes_left", exp_q.size(), 0);
        exp_q.delete(); exp_g.delete();

        // Asynchronous reset in the middle of a 5-byte payload
        pa = '{8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h00, 8'h00, 8'h00};
        start_packet(0, 5, pa, ref_crc(pa, 5));
        seen = 0; t = 0;
        while (seen < 2 && t < TO) begin
            @(negedge clk); t++;
            if (rd0) seen++;
        end
        chk("reset_reached_pay", seen, 2);
        chk("busy_before_reset", int'(busy), 1);
        #20 rst_n = 1'b0;
        #1 chk("async_reset", int'(outs()), 0);
        exp_q.delete(); exp_g.delete();
        push_packet(5, pa, ref_crc(pa, 5));
        exp_g.push_back(0);
        repeat (2) @(negedge clk);
        chk("held_in_reset", int'(outs()), 0);
        snap();
        rst_n = 1'b1;
        finish_packet(0, 5);
        exp_q.delete(); exp_g.delete();

        // req0 withdrawn after the first payload byte, stray tx_done pulses
        pa = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'h00, 8'h00};
        stray_en = 1'b1;
        start_packet(0, 6, pa, ref_crc(pa, 6));
        t = 0;
        while (!rd0 && t < TO) begin @(negedge clk); t++; end
        chk("drop_reached_pay", int'(rd0), 1);
        req0 = 1'b0;
        finish_packet(0, 6);
        stray_en = 1'b0;

        chk("grant_exclusive", int'(excl_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
